tile_state_mem: RTL and testbench

- Single-port synchronous-write, asynchronous-read RAM holding the per-cell game state: 2**ADDR_W entries, each DATA_W bits wide.
- Sits between game logic, which saves cell states by address, and the renderer, which combinationally looks up a state by address.
- After reset, a built-in sweep clears every entry to zero. A busy flag marks the sweep.

---
 rtl/tile_state_mem.sv | 118 +++++++++++
 tb/tb_tile_state_mem.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/tile_state_mem.sv
// ---------------------------------------------------------------------------
// tile_state_mem
//   Per-cell game state store. One shared address port: game logic writes
//   cell states synchronously, the renderer reads them back by address.
//   After reset a built-in sweep clears all 2**ADDR_W entries to zero; busy
//   is high while reset is asserted and for the whole sweep.
//
// Parameters
//   ADDR_W  address width, depth is 2**ADDR_W entries
//   DATA_W  width of one stored cell state
//
// Ports
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   wr     write enable (ignored while busy)
//   addr   shared read/write address
//   di     write data
//   dout   read data for addr (zero while busy)
//   busy   reset asserted or clear sweep in progress
//
// Build option
//   MEM_READ_REG_EN  when defined, dout is registered (1-cycle latency,
//                    read-before-write on a same-address collision).
//                    When undefined, dout is a combinational lookup.
// ---------------------------------------------------------------------------
module tile_state_mem #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] di,
  output logic [DATA_W-1:0] dout,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              ptr_last;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;

  assign ptr_last = &ptr;

  // State register and clear pointer.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) ptr <= ptr + ADDR_W'(1);
    end
  end

  // Next-state logic: leave CLEAR on the edge that clears the last entry.
  // NOTE: default assignment first so no path leaves state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    if (state == CLEAR && ptr_last) state_nxt = READY;
  end

  // Output logic: busy flag and write-port steering. During the sweep the
  // user write port is disconnected, so wr is dropped rather than queued.
  always_comb begin
    busy   = (state == CLEAR);
    mem_we = 1'b0;
    mem_wa = addr;
    mem_wd = di;
    if (state == CLEAR) begin
      mem_we = 1'b1;
      mem_wa = ptr;
      mem_wd = '0;
    end else begin
      mem_we = wr;
    end
  end

  // NOTE: the array has no reset; clearing it is the job of the sweep, which
  // keeps it mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_data = mem[addr];

`ifdef MEM_READ_REG_EN
  // Registered read: samples pre-edge contents, so a same-address write on
  // the same edge returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dout <= '0;
    else        dout <= (state == READY) ? rd_data : '0;
  end
`else
  // Combinational read: zero latency, masked to zero while clearing.
  always_comb begin
    dout = (state == READY) ? rd_data : '0;
  end
`endif

endmodule

// File: tb/tb_tile_state_mem.sv
// ---------------------------------------------------------------------------
// tb_tile_state_mem
//   Directed bench for tile_state_mem. Two instances share one clock:
//   a 4-bit-address copy for sweep length, dropped writes and mid-sweep
//   reset, and the default 16-bit copy for the full 65536-cycle sweep,
//   save/load, read-during-write and full-width data.
// ---------------------------------------------------------------------------
module tb_tile_state_mem;

  logic        clk;
  logic        rst_n, rst_n4;
  logic        wr, wr4;
  logic [15:0] addr;
  logic [3:0]  addr4;
  logic [2:0]  di, di4;
  logic [2:0]  dout, dout4;
  logic        busy, busy4;

  int n_vec = 0;
  int n_err = 0;

  tile_state_mem #(.ADDR_W(16), .DATA_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr), .addr(addr), .di(di),
    .dout(dout), .busy(busy)
  );

  tile_state_mem #(.ADDR_W(4), .DATA_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n4), .wr(wr4), .addr(addr4), .di(di4),
    .dout(dout4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Read helpers: combinational build looks up without a clock, registered
  // build needs one edge for the data to appear.
  task automatic rd(input string tag, input logic [15:0] a,
                    input logic [2:0] exp);
    addr = a;
`ifdef MEM_READ_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    check(tag, 32'(dout), 32'(exp));
  endtask

  task automatic rd4(input string tag, input logic [3:0] a,
                     input logic [2:0] exp);
    addr4 = a;
`ifdef MEM_READ_REG_EN
    @(posedge clk); #1;
`else
    #1;
`endif
    check(tag, 32'(dout4), 32'(exp));
  endtask

  task automatic wr_op(input logic [15:0] a, input logic [2:0] d);
    wr = 1'b1; addr = a; di = d;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic wr4_op(input logic [3:0] a, input logic [2:0] d);
    wr4 = 1'b1; addr4 = a; di4 = d;
    @(posedge clk); #1;
    wr4 = 1'b0;
  endtask

  // Counts edges from now until busy4 falls (bounded).
  task automatic sweep4(output int cycles);
    cycles = 0;
    while (busy4 && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; wr = 1'b0; addr = '0; di = '0;
    rst_n4 = 1'b0; wr4 = 1'b0; addr4 = '0; di4 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // ---------------- small instance ----------------
    check("reset_busy4", 32'(busy4), 32'd1);
    check("reset_dout4", 32'(dout4), 32'd0);

    // Release with a write to addr 5 held through the sweep: must be dropped.
    rst_n4 = 1'b1;
    wr4 = 1'b1; addr4 = 4'd5; di4 = 3'd7;
    cyc = 0;
    while (busy4 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 8) check("clear_dout_zero", 32'(dout4), 32'd0);
    end
    wr4 = 1'b0;
    check("sweep4_len", 32'(cyc), 32'd16);
    for (int i = 0; i < 16; i++) rd4($sformatf("clr4_a%0d", i), 4'(i), 3'd0);

    // Reset in READY then mid-sweep reset; the stored 7 must not survive.
    wr4_op(4'd9, 3'd7);
    rd4("ready_wr9", 4'd9, 3'd7);
    rst_n4 = 1'b0; #1;
    check("ready_rst_busy", 32'(busy4), 32'd1);
    check("ready_rst_dout", 32'(dout4), 32'd0);
    @(posedge clk); #1;
    rst_n4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
    end
    check("mid_sweep_busy", 32'(busy4), 32'd1);
    rst_n4 = 1'b0; #1;
    check("mid_rst_busy", 32'(busy4), 32'd1);
    @(posedge clk); #1;
    rst_n4 = 1'b1;
    sweep4(cyc);
    check("resweep4_len", 32'(cyc), 32'd16);
    rd4("resweep_a9", 4'd9, 3'd0);

    // ---------------- default instance ----------------
    check("reset_busy", 32'(busy), 32'd1);
    check("reset_dout", 32'(dout), 32'd0);
    rst_n = 1'b1;
    cyc = 0;
    while (busy && cyc < 65546) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("sweep_len", 32'(cyc), 32'd65536);
    rd("clr_a0", 16'd0, 3'd0);
    rd("clr_a1", 16'd1, 3'd0);
    rd("clr_a163", 16'd163, 3'd0);
    rd("clr_a65535", 16'd65535, 3'd0);

    // Save/load.
    wr_op(16'd163, 3'd1);
    wr_op(16'd164, 3'd2);
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    rd("load_163", 16'd163, 3'd1);
    rd("load_164", 16'd164, 3'd2);

    // Read-during-write at addr 20 holding 3.
    wr_op(16'd20, 3'd3);
    rd("rdw_pre", 16'd20, 3'd3);
    wr = 1'b1; addr = 16'd20; di = 3'd6;
`ifdef MEM_READ_REG_EN
    @(posedge clk); #1;
    wr = 1'b0;
    check("rdw_after_edge", 32'(dout), 32'd3);
    @(posedge clk); #1;
    check("rdw_next_cycle", 32'(dout), 32'd6);
`else
    #1;
    check("rdw_before_edge", 32'(dout), 32'd3);
    @(posedge clk); #1;
    wr = 1'b0;
    check("rdw_after_edge", 32'(dout), 32'd6);
`endif

    // Full-width data at both ends of the array.
    wr_op(16'd0, 3'd7);
    wr_op(16'd65535, 3'd7);
    rd("fw_a0", 16'd0, 3'd7);
    rd("fw_a65535", 16'd65535, 3'd7);
    rd("fw_a1", 16'd1, 3'd0);
    rd("fw_a65534", 16'd65534, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
